// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// HLT opcode, reset PC, bubble word and opcode-field helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_HALT  = 2'b10
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEF    = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;
  localparam logic [15:0] NOP_INSTR       = 16'h0000;
  localparam logic [15:0] PC_STEP         = 16'h0002;
  localparam logic [15:0] PC_ALIGN_MASK   = 16'hFFFE;

  // Opcode field of an instruction word.
  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/fetch_stage_add_sub.sv
// 16-bit adder/subtractor with signed-overflow flag; used as the PC+2
// incrementer in the fetch stage.
module Add_Sub_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        sub,
  output logic [15:0] Sum,
  output logic        Ovfl
);

  logic [15:0] b_eff;

  // Two's-complement add, or subtract by adding ~B + 1.
  always_comb begin
    b_eff = sub ? ~B : B;
    Sum   = A + b_eff + {15'd0, sub};
    Ovfl  = (A[15] == b_eff[15]) && (Sum[15] != A[15]);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory port,
// absorbs misses and hazard stalls, and loads the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_ack,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic [15:0] pc,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_d;
  logic [15:0]  hold_q, hold_d;
  logic [15:0]  instr_d, pc_plus2_d;
  logic         valid_d;
  logic [15:0]  pc_plus2;
  logic         unused_ovfl;

  Add_Sub_16bit u_pc_inc (
    .A    (pc),
    .B    (PC_STEP),
    .sub  (1'b0),
    .Sum  (pc_plus2),
    .Ovfl (unused_ovfl)
  );

  // Memory request and halt indication follow directly from the state.
  always_comb begin
    imem_req  = (state_q == ST_FETCH);
    imem_addr = pc;
    halted    = (state_q == ST_HALT);
  end

  // Next-state logic: a taken branch wins over everything, otherwise the
  // state decides whether memory data, the hold buffer or nothing is issued.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    hold_d     = hold_q;
    instr_d    = if_id_instr;
    pc_plus2_d = if_id_pc_plus2;
    valid_d    = if_id_valid;

    if (branch_taken) begin
      pc_d    = branch_target & PC_ALIGN_MASK;
      valid_d = 1'b0;
      hold_d  = NOP_INSTR;
      state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (imem_ack && stall) begin
            hold_d  = imem_data;
            state_d = ST_HOLD;
          end else if (imem_ack) begin
            instr_d    = imem_data;
            pc_plus2_d = pc_plus2;
            valid_d    = 1'b1;
            if (opcode_of(imem_data) == HALT_OPCODE) state_d = ST_HALT;
            else                                     pc_d    = pc_plus2;
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            instr_d    = hold_q;
            pc_plus2_d = pc_plus2;
            valid_d    = 1'b1;
            if (opcode_of(hold_q) == HALT_OPCODE) begin
              state_d = ST_HALT;
            end else begin
              pc_d    = pc_plus2;
              state_d = ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          if (!stall) valid_d = 1'b0;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // State, PC, hold buffer and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FETCH;
      pc             <= RESET_PC;
      hold_q         <= NOP_INSTR;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus2 <= 16'h0000;
      if_id_valid    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc             <= pc_d;
      hold_q         <= hold_d;
      if_id_instr    <= instr_d;
      if_id_pc_plus2 <= pc_plus2_d;
      if_id_valid    <= valid_d;
    end
  end

endmodule
